// File: rtl/time_pkg.sv
// Shared constants, FSM state type and load-validation helper for the BCD time-of-day counter.
package time_pkg;

  localparam int unsigned SEC_T_MAX     = 5;
  localparam int unsigned MIN_T_MAX     = 5;
  localparam int unsigned HR_T_MAX      = 2;
  localparam int unsigned HR_U_MAX_AT_2 = 3;
  localparam int unsigned DIG_MAX       = 9;

  localparam int unsigned SEC_U_OFF = 0;
  localparam int unsigned SEC_T_OFF = 4;
  localparam int unsigned MIN_U_OFF = 8;
  localparam int unsigned MIN_T_OFF = 12;
  localparam int unsigned HR_U_OFF  = 16;
  localparam int unsigned HR_T_OFF  = 20;

  typedef enum logic [0:0] {PAUSE, RUN} state_e;

  function automatic logic time_legal(input logic [23:0] t);
    logic [3:0] su, st, mu, mt, hu, ht;
    logic       ok;
    su = t[SEC_U_OFF +: 4];
    st = t[SEC_T_OFF +: 4];
    mu = t[MIN_U_OFF +: 4];
    mt = t[MIN_T_OFF +: 4];
    hu = t[HR_U_OFF +: 4];
    ht = t[HR_T_OFF +: 4];
    ok = (su <= 4'(DIG_MAX)) && (mu <= 4'(DIG_MAX)) && (hu <= 4'(DIG_MAX)) &&
         (st <= 4'(SEC_T_MAX)) && (mt <= 4'(MIN_T_MAX)) && (ht <= 4'(HR_T_MAX));
    if (ht == 4'(HR_T_MAX) && hu > 4'(HR_U_MAX_AT_2)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counter: load beats clear beats increment; wraps to 0 after Max.
module bcd_digit #(
  parameter int unsigned Max = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic       carry_o
);

  localparam logic [3:0] MaxVal = 4'(Max);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (clr_i) begin
      q_d = 4'd0;
    end else if (inc_i) begin
      q_d = (q_q == MaxVal) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i && (q_q == MaxVal);

endmodule

// File: rtl/time_bcd_counter.sv
// 24-hour HH:MM:SS BCD clock driven by a 1 s divider, with run/pause and validated time load.
module time_bcd_counter
  import time_pkg::*;
#(
  parameter int unsigned TickDiv = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        set_vld_i,
  input  logic [23:0] set_data_i,
  output logic [23:0] time_bcd_o,
  output logic        sec_pulse_o,
  output logic        day_pulse_o,
  output logic        set_err_o
);

  localparam int unsigned CntW    = $clog2(TickDiv);
  localparam logic [CntW-1:0] CntLast = CntW'(TickDiv - 1);

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            sec_pulse_d, sec_pulse_q;
  logic            day_pulse_d, day_pulse_q;
  logic            set_err_d, set_err_q;
  logic            en, tick, load_ok, adv, hr_wrap;
  logic [3:0]      sec_u, sec_t, min_u, min_t, hr_u, hr_t;
  logic            sec_u_c, sec_t_c, min_u_c, min_t_c, hr_u_c, hr_t_c;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PAUSE:   if (run_i) state_d = RUN;
      RUN:     if (!run_i) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  // The divider only moves once the registered state has caught up with run_i.
  assign en      = run_i && (state_q == RUN);
  assign tick    = en && (cnt_q == CntLast);
  assign load_ok = set_vld_i && time_legal(set_data_i);
  assign adv     = tick && !load_ok;
  assign hr_wrap = min_t_c && (hr_t == 4'(HR_T_MAX)) && (hr_u == 4'(HR_U_MAX_AT_2));

  always_comb begin
    cnt_d = cnt_q;
    if (load_ok || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
    sec_pulse_d = adv;
    day_pulse_d = hr_wrap;
    set_err_d   = set_vld_i && !load_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PAUSE;
      cnt_q       <= '0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      set_err_q   <= set_err_d;
    end
  end

  bcd_digit #(.Max(DIG_MAX)) u_sec_u (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(adv), .clr_i(1'b0), .load_i(load_ok),
    .load_val_i(set_data_i[SEC_U_OFF +: 4]), .q_o(sec_u), .carry_o(sec_u_c)
  );
  bcd_digit #(.Max(SEC_T_MAX)) u_sec_t (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(sec_u_c), .clr_i(1'b0), .load_i(load_ok),
    .load_val_i(set_data_i[SEC_T_OFF +: 4]), .q_o(sec_t), .carry_o(sec_t_c)
  );
  bcd_digit #(.Max(DIG_MAX)) u_min_u (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(sec_t_c), .clr_i(1'b0), .load_i(load_ok),
    .load_val_i(set_data_i[MIN_U_OFF +: 4]), .q_o(min_u), .carry_o(min_u_c)
  );
  bcd_digit #(.Max(MIN_T_MAX)) u_min_t (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(min_u_c), .clr_i(1'b0), .load_i(load_ok),
    .load_val_i(set_data_i[MIN_T_OFF +: 4]), .q_o(min_t), .carry_o(min_t_c)
  );
  bcd_digit #(.Max(DIG_MAX)) u_hr_u (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(min_t_c), .clr_i(hr_wrap), .load_i(load_ok),
    .load_val_i(set_data_i[HR_U_OFF +: 4]), .q_o(hr_u), .carry_o(hr_u_c)
  );
  // Hour tens never carries from legal state; clearing on it keeps the pair sane regardless.
  bcd_digit #(.Max(HR_T_MAX)) u_hr_t (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(hr_u_c), .clr_i(hr_wrap || hr_t_c), .load_i(load_ok),
    .load_val_i(set_data_i[HR_T_OFF +: 4]), .q_o(hr_t), .carry_o(hr_t_c)
  );

  assign time_bcd_o  = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
  assign sec_pulse_o = sec_pulse_q;
  assign day_pulse_o = day_pulse_q;
  assign set_err_o   = set_err_q;

endmodule

// File: doc/time_bcd_counter.md
# time_bcd_counter

Timekeeping stage feeding the six-digit seven-segment scan driver. Divides the 50 MHz board clock to a 1 s tick and keeps a 24-hour HH:MM:SS time as six packed BCD digits. Supports run/pause and a validated parallel time load. Outputs are registered and drive the digit-data input of the display driver directly.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per second tick; legal range 2 and above; simulation uses 4.
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = time advances, 0 = paused (divider holds)
- set_vld  in  1  one-cycle load request
- set_data  in  24  packed BCD time, bit layout identical to time_bcd
- time_bcd  out  24  current time: [23:20] hour tens, [19:16] hour units, [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units
- sec_pulse  out  1  one-cycle pulse when seconds advance
- day_pulse  out  1  one-cycle pulse on 23:59:59 to 00:00:00 wrap
- set_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Divider: tick_cnt, width clog2(TICK_DIV), counts 0..TICK_DIV-1 while run=1 and wraps to 0. tick = run && tick_cnt==TICK_DIV-1.
- On tick the six-digit chain advances:
  - second units 0-9, carry into second tens 0-5
  - minute units 0-9, carry into minute tens 0-5
  - hour pair runs 00-23: hour units wraps at 9 to hour tens +1; at 23, both hour digits go to 0
- Full rollover: 23:59:59 to 00:00:00, with day_pulse and sec_pulse both asserted.
- Load validation. set_data is legal only if all of the following hold:
  - each digit is 9 or less
  - second tens and minute tens are 5 or less
  - hour tens is 2 or less
  - when hour tens is 2, hour units is 3 or less
- Legal load: time_bcd <= set_data and tick_cnt <= 0 on the next edge. No sec_pulse is produced for the load itself.
- Illegal load: time_bcd and tick_cnt are unchanged; set_err pulses.
- Loads are accepted regardless of run.
- Priority when set_vld and tick occur in the same cycle: the load wins and the tick is discarded.
  - Legal load: the divider restarts from 0.
  - Illegal load: the tick proceeds normally and set_err pulses.
- Pause: when run falls, tick_cnt holds its value. When run rises, counting resumes from the held value; no tick is lost or duplicated.
- Control FSM with two states, PAUSE and RUN:
  - reset enters PAUSE
  - PAUSE to RUN when run=1
  - RUN to PAUSE when run=0
  - The state is registered, so advancing begins one cycle after run rises.

## Timing
- Reset values: time_bcd = 24'h000000, tick_cnt = 0, state = PAUSE, sec_pulse = day_pulse = set_err = 0.
- Reset is asynchronous. Asserting it mid-count or mid-load clears everything immediately; a load pending at that moment is discarded.
- Latency from a tick cycle to updated time_bcd and to sec_pulse: 1 clk. Both appear on the same edge.
- Latency from a set_vld cycle to time_bcd or set_err: 1 clk.
- With run held at 1 from PAUSE, the first sec_pulse arrives TICK_DIV+1 cycles after run rises.
- All outputs are driven directly from flops; there is no combinational path from any input to any output.

## Structure
- Package time_pkg holds:
  - localparams for digit moduli: SEC_T_MAX=5, MIN_T_MAX=5, HR_T_MAX=2, HR_U_MAX_AT_2=3, DIG_MAX=9
  - the FSM state enum {PAUSE, RUN}
  - the bit-field offset constants for the packed time word
- Sub-module bcd_digit: one 4-bit BCD digit with max parameter, and inc, clr, load and load_val inputs. It produces carry = inc && q==max.
  - Instantiated six times.
  - The hour pair adds wrap logic at the top level for the 23 to 00 rule.

## Test plan
(TICK_DIV=4 for all scenarios.)
- Reset, then run=1 for 5 cycles: time_bcd=000000 until the first sec_pulse, then 000001; each later sec_pulse is spaced exactly 4 cycles apart.
- Load 235958, run 2 ticks: time_bcd reads 235959 then 000000. day_pulse is high only on the second tick edge.
- Load 095959, one tick: result 100000. Load 195959, one tick: result 200000.
- Load 240000, then 126000, then 0A0000: each gives set_err for one cycle and time_bcd unchanged.
- set_vld with 123456 in the same cycle as tick: time_bcd=123456, no sec_pulse, and the next sec_pulse comes 4 cycles later with value 123457.
- Drop run at tick_cnt=2 for 10 cycles, then raise it: the next sec_pulse arrives 2 cycles after counting resumes. Assert rst mid-count: all outputs clear within the same cycle.
